// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the RISC-V load/store unit: funct3 access sizes,
// FSM state type and the size legality helper.
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   function automatic logic size_legal(input logic [2:0] size);
      logic ok;
      case (size)
         LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: ok = 1'b1;
         default:                                  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Combinational load lane select: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  size_i,
   output logic [31:0] result_o
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      byte_s   = word_i[{offset_i, 3'b000} +: 8];
      // halfword accesses are already known to be 2-byte aligned
      half_s   = word_i[{offset_i[1], 4'b0000} +: 16];
      result_o = 32'h0;
      case (size_i)
         LDST_B:  result_o = {{24{byte_s[7]}}, byte_s};
         LDST_H:  result_o = {{16{half_s[15]}}, half_s};
         LDST_W:  result_o = word_i;
         LDST_BU: result_o = {24'h0, byte_s};
         LDST_HU: result_o = {16'h0, half_s};
         default: result_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: accepts one core access, runs it against
// a ready-handshaked memory port and returns the extended load data.
module riscv_lsu
   import riscv_lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size[1:0])
         2'd0:    be = 4'b0001 << off;
         2'd1:    be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
      logic [31:0] rep;
      case (size[1:0])
         2'd0:    rep = {4{wd[7:0]}};
         2'd1:    rep = {2{wd[15:0]}};
         default: rep = wd;
      endcase
      return rep;
   endfunction

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rd_q, rd_d;

   logic        misaligned;
   logic        req_bad;
   logic        accept;
   logic [31:0] load_res;

   lsu_load_align u_align (
      .word_i   (mem_rd_i),
      .offset_i (addr_q[1:0]),
      .size_i   (size_q),
      .result_o (load_res)
   );

   always_comb begin
      misaligned = (((core_size_i == LDST_H) || (core_size_i == LDST_HU)) && core_addr_i[0])
                || ((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00));
      req_bad    = !size_legal(core_size_i) || misaligned;
      accept     = (state_q == IDLE) && core_req_i && !req_bad;
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      be_d    = be_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = core_we_i;
               size_d  = core_size_i;
               addr_d  = core_addr_i;
               wd_d    = store_wd(core_size_i, core_wd_i);
               be_d    = core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'b1111;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready_i) begin
               if (!we_q) rd_d = load_res;
               state_d = DONE;
            end
         end
         // the core's request is still visible here for the retiring access
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 3'd0;
         addr_q  <= 32'h0;
         wd_q    <= 32'h0;
         be_q    <= 4'h0;
         rd_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
      end
   end

   // Stall/err depend on the live request, so they are gated by reset explicitly.
   always_comb begin
      core_stall_o = !rst_i && (accept || (state_q == BUSY));
      core_err_o   = !rst_i && (state_q == IDLE) && core_req_i && req_bad;
      core_rd_o    = rd_q;
      mem_req_o    = (state_q == BUSY);
      mem_we_o     = (state_q == BUSY) && we_q;
      mem_be_o     = be_q;
      mem_addr_o   = {addr_q[31:2], 2'b00};
      mem_wd_o     = wd_q;
   end

endmodule
